// File: rtl/mem_stage.sv
// Memory stage: accepts one instruction from EX, performs any data-cache
// access over dREN/dWEN/dhit, and registers the MEM/WB fields for writeback.
module mem_stage #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REGSEL_W = 5,
  parameter int unsigned SRC_W    = 2
) (
  input  logic                CLK,
  input  logic                RST,
  // EX side
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [WORD_W-1:0]   ex_alu_result,
  input  logic [WORD_W-1:0]   ex_store_data,
  input  logic [WORD_W-1:0]   ex_instr_npc,
  input  logic [REGSEL_W-1:0] ex_wsel,
  input  logic                ex_wen,
  input  logic [SRC_W-1:0]    ex_wdat_source,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic                ex_halt,
  // data cache side
  output logic                dREN,
  output logic                dWEN,
  output logic [WORD_W-1:0]   daddr,
  output logic [WORD_W-1:0]   dstore,
  input  logic                dhit,
  input  logic [WORD_W-1:0]   dmemload,
  // MEM/WB fields
  output logic                wb_valid,
  output logic [WORD_W-1:0]   wb_alu_result,
  output logic [WORD_W-1:0]   wb_dmemload,
  output logic [WORD_W-1:0]   wb_instr_npc,
  output logic [REGSEL_W-1:0] wb_wsel,
  output logic                wb_wen,
  output logic [SRC_W-1:0]    wb_wdat_source,
  output logic                wb_halt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Instruction parked while its data access is outstanding.
  typedef struct packed {
    logic [WORD_W-1:0]   alu_result;
    logic [WORD_W-1:0]   store_data;
    logic [WORD_W-1:0]   instr_npc;
    logic [REGSEL_W-1:0] wsel;
    logic                wen;
    logic [SRC_W-1:0]    wdat_source;
    logic                mem_read;
    logic                mem_write;
  } held_t;

  state_t                state_q;
  held_t                 held_q;
  logic                  wb_valid_q;
  logic [WORD_W-1:0]     wb_alu_result_q;
  logic [WORD_W-1:0]     wb_dmemload_q;
  logic [WORD_W-1:0]     wb_instr_npc_q;
  logic [REGSEL_W-1:0]   wb_wsel_q;
  logic                  wb_wen_q;
  logic [SRC_W-1:0]      wb_wdat_source_q;
  logic                  wb_halt_q;

  logic                  in_access;
  logic                  accept;

  assign in_access = (state_q == ACCESS);
  assign ex_ready  = (state_q == IDLE);
  assign accept    = ex_valid & ex_ready;

  // Cache request is a decode of the held instruction; forced low outside ACCESS.
  always_comb begin
    dWEN   = in_access & held_q.mem_write;
    dREN   = in_access & held_q.mem_read & ~held_q.mem_write;
    daddr  = in_access ? {held_q.alu_result[WORD_W-1:2], 2'b00} : '0;
    dstore = in_access ? held_q.store_data : '0;
  end

  // Control FSM together with the held instruction and MEM/WB registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= IDLE;
      held_q           <= '0;
      wb_valid_q       <= 1'b0;
      wb_alu_result_q  <= '0;
      wb_dmemload_q    <= '0;
      wb_instr_npc_q   <= '0;
      wb_wsel_q        <= '0;
      wb_wen_q         <= 1'b0;
      wb_wdat_source_q <= '0;
      wb_halt_q        <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (ex_halt) begin
              wb_valid_q       <= 1'b1;
              wb_alu_result_q  <= ex_alu_result;
              wb_dmemload_q    <= '0;
              wb_instr_npc_q   <= ex_instr_npc;
              wb_wsel_q        <= ex_wsel;
              wb_wen_q         <= ex_wen;
              wb_wdat_source_q <= ex_wdat_source;
              wb_halt_q        <= 1'b1;
              state_q          <= HALTED;
            end else if (ex_mem_read | ex_mem_write) begin
              held_q.alu_result  <= ex_alu_result;
              held_q.store_data  <= ex_store_data;
              held_q.instr_npc   <= ex_instr_npc;
              held_q.wsel        <= ex_wsel;
              held_q.wen         <= ex_wen;
              held_q.wdat_source <= ex_wdat_source;
              held_q.mem_read    <= ex_mem_read;
              held_q.mem_write   <= ex_mem_write;
              state_q            <= ACCESS;
            end else begin
              wb_valid_q       <= 1'b1;
              wb_alu_result_q  <= ex_alu_result;
              wb_dmemload_q    <= '0;
              wb_instr_npc_q   <= ex_instr_npc;
              wb_wsel_q        <= ex_wsel;
              wb_wen_q         <= ex_wen;
              wb_wdat_source_q <= ex_wdat_source;
            end
          end
        end
        ACCESS: begin
          if (dhit) begin
            wb_valid_q       <= 1'b1;
            wb_alu_result_q  <= held_q.alu_result;
            wb_dmemload_q    <= held_q.mem_write ? '0 : dmemload;
            wb_instr_npc_q   <= held_q.instr_npc;
            wb_wsel_q        <= held_q.wsel;
            wb_wen_q         <= held_q.wen;
            wb_wdat_source_q <= held_q.wdat_source;
            state_q          <= IDLE;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_alu_result  = wb_alu_result_q;
  assign wb_dmemload    = wb_dmemload_q;
  assign wb_instr_npc   = wb_instr_npc_q;
  assign wb_wsel        = wb_wsel_q;
  assign wb_wen         = wb_wen_q;
  assign wb_wdat_source = wb_wdat_source_q;
  assign wb_halt        = wb_halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, load, store, halt, reset mid-access, streaming.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [31:0] ex_instr_npc;
  logic [4:0]  ex_wsel;
  logic        ex_wen;
  logic [1:0]  ex_wdat_source;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_halt;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_dmemload;
  logic [31:0] wb_instr_npc;
  logic [4:0]  wb_wsel;
  logic        wb_wen;
  logic [1:0]  wb_wdat_source;
  logic        wb_halt;

  int unsigned total;
  int unsigned bad;

  mem_stage dut (
    .CLK            (clk),
    .RST            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_instr_npc   (ex_instr_npc),
    .ex_wsel        (ex_wsel),
    .ex_wen         (ex_wen),
    .ex_wdat_source (ex_wdat_source),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_halt        (ex_halt),
    .dREN           (dren),
    .dWEN           (dwen),
    .daddr          (daddr),
    .dstore         (dstore),
    .dhit           (dhit),
    .dmemload       (dmemload),
    .wb_valid       (wb_valid),
    .wb_alu_result  (wb_alu_result),
    .wb_dmemload    (wb_dmemload),
    .wb_instr_npc   (wb_instr_npc),
    .wb_wsel        (wb_wsel),
    .wb_wen         (wb_wen),
    .wb_wdat_source (wb_wdat_source),
    .wb_halt        (wb_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid       = 1'b0;
    ex_alu_result  = '0;
    ex_store_data  = '0;
    ex_instr_npc   = '0;
    ex_wsel        = '0;
    ex_wen         = 1'b0;
    ex_wdat_source = '0;
    ex_mem_read    = 1'b0;
    ex_mem_write   = 1'b0;
    ex_halt        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    dhit     = 1'b0;
    dmemload = '0;
    clear_ex();
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_dren",     32'(dren),     32'd0);
    check("rst_dwen",     32'(dwen),     32'd0);
    check("rst_wb_halt",  32'(wb_halt),  32'd0);
    check("rst_wb_alu",   wb_alu_result, 32'd0);

    // 1: single ALU op, one-cycle latency
    ex_valid       = 1'b1;
    ex_alu_result  = 32'h0000_1234;
    ex_instr_npc   = 32'h0000_0104;
    ex_wsel        = 5'd5;
    ex_wen         = 1'b1;
    ex_wdat_source = 2'd0;
    step();
    clear_ex();
    check("alu_wb_valid", 32'(wb_valid),   32'd1);
    check("alu_result",   wb_alu_result,   32'h0000_1234);
    check("alu_wsel",     32'(wb_wsel),    32'd5);
    check("alu_wen",      32'(wb_wen),     32'd1);
    check("alu_npc",      wb_instr_npc,    32'h0000_0104);
    // idle cycle: bubble, with dhit outside ACCESS ignored
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    check("idle_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_wb_wen",   32'(wb_wen),   32'd0);
    check("idle_hold_alu", wb_alu_result, 32'h0000_1234);
    check("idle_ex_ready", 32'(ex_ready), 32'd1);

    // 2: load from 0x103, hit on the third request cycle
    ex_valid       = 1'b1;
    ex_alu_result  = 32'h0000_0103;
    ex_instr_npc   = 32'h0000_0208;
    ex_wsel        = 5'd7;
    ex_wen         = 1'b1;
    ex_wdat_source = 2'd1;
    ex_mem_read    = 1'b1;
    step();
    clear_ex();
    check("ld_bubble", 32'(wb_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("ld_dren",     32'(dren),     32'd1);
      check("ld_dwen",     32'(dwen),     32'd0);
      check("ld_daddr",    daddr,         32'h0000_0100);
      check("ld_ex_ready", 32'(ex_ready), 32'd0);
      check("ld_wait_val", 32'(wb_valid), 32'd0);
      if (i == 2) begin
        dhit     = 1'b1;
        dmemload = 32'hDEAD_BEEF;
      end
      step();
    end
    dhit     = 1'b0;
    dmemload = '0;
    check("ld_wb_valid", 32'(wb_valid),       32'd1);
    check("ld_dmemload", wb_dmemload,         32'hDEAD_BEEF);
    check("ld_alu",      wb_alu_result,       32'h0000_0103);
    check("ld_wsel",     32'(wb_wsel),        32'd7);
    check("ld_src",      32'(wb_wdat_source), 32'd1);
    check("ld_npc",      wb_instr_npc,        32'h0000_0208);
    check("ld_done_rdy", 32'(ex_ready),       32'd1);
    check("ld_done_ren", 32'(dren),           32'd0);

    // 3: store with read and write both set, hit on first request cycle
    ex_valid      = 1'b1;
    ex_alu_result = 32'h0000_0040;
    ex_store_data = 32'h0000_CAFE;
    ex_wsel       = 5'd9;
    ex_wen        = 1'b0;
    ex_mem_read   = 1'b1;
    ex_mem_write  = 1'b1;
    step();
    clear_ex();
    check("st_dwen",   32'(dwen), 32'd1);
    check("st_dren",   32'(dren), 32'd0);
    check("st_dstore", dstore,    32'h0000_CAFE);
    check("st_daddr",  daddr,     32'h0000_0040);
    dhit     = 1'b1;
    dmemload = 32'h1111_2222;
    step();
    dhit     = 1'b0;
    dmemload = '0;
    check("st_wb_valid", 32'(wb_valid), 32'd1);
    check("st_wb_wen",   32'(wb_wen),   32'd0);
    check("st_dmemload", wb_dmemload,   32'd0);
    check("st_done_wen", 32'(dwen),     32'd0);
    check("st_dstore0",  dstore,        32'd0);

    // 5: reset while a load is waiting
    ex_valid      = 1'b1;
    ex_alu_result = 32'h0000_0200;
    ex_mem_read   = 1'b1;
    ex_wen        = 1'b1;
    step();
    clear_ex();
    check("rs_pre_dren", 32'(dren), 32'd1);
    do_reset();
    check("rs_dren",     32'(dren),     32'd0);
    check("rs_dwen",     32'(dwen),     32'd0);
    check("rs_daddr",    daddr,         32'd0);
    check("rs_wb_valid", 32'(wb_valid), 32'd0);
    check("rs_ex_ready", 32'(ex_ready), 32'd1);
    ex_valid      = 1'b1;
    ex_alu_result = 32'h0000_0055;
    ex_wsel       = 5'd3;
    ex_wen        = 1'b1;
    step();
    clear_ex();
    check("rs_alu_valid", 32'(wb_valid), 32'd1);
    check("rs_alu_res",   wb_alu_result, 32'h0000_0055);
    check("rs_alu_wsel",  32'(wb_wsel),  32'd3);

    // 6: eight back-to-back ALU ops, including wsel=0 passthrough
    for (int i = 0; i < 8; i++) begin
      ex_valid       = 1'b1;
      ex_alu_result  = 32'h0000_1000 + 32'(i);
      ex_instr_npc   = 32'h0000_2000 + 32'(4 * i);
      ex_wsel        = 5'(i);
      ex_wen         = 1'b1;
      ex_wdat_source = 2'(i % 3);
      check("b2b_ready", 32'(ex_ready), 32'd1);
      step();
      check("b2b_valid", 32'(wb_valid),       32'd1);
      check("b2b_alu",   wb_alu_result,       32'h0000_1000 + 32'(i));
      check("b2b_npc",   wb_instr_npc,        32'h0000_2000 + 32'(4 * i));
      check("b2b_wsel",  32'(wb_wsel),        32'(i));
      check("b2b_src",   32'(wb_wdat_source), 32'(i % 3));
    end
    clear_ex();
    step();

    // 4: halt, then EX keeps pushing a load for 20 cycles
    ex_valid      = 1'b1;
    ex_halt       = 1'b1;
    ex_alu_result = 32'h0000_0099;
    step();
    ex_halt     = 1'b0;
    ex_mem_read = 1'b1;
    check("h_wb_halt",  32'(wb_halt),  32'd1);
    check("h_wb_valid", 32'(wb_valid), 32'd1);
    check("h_wb_alu",   wb_alu_result, 32'h0000_0099);
    check("h_ex_ready", 32'(ex_ready), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("h_hold_rdy",  32'(ex_ready), 32'd0);
      check("h_hold_ren",  32'(dren),     32'd0);
      check("h_hold_wen",  32'(dwen),     32'd0);
      check("h_hold_halt", 32'(wb_halt),  32'd1);
      check("h_hold_val",  32'(wb_valid), 32'd0);
      check("h_hold_rwen", 32'(wb_wen),   32'd0);
    end
    clear_ex();
    do_reset();
    check("h_rst_halt",  32'(wb_halt),  32'd0);
    check("h_rst_ready", 32'(ex_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
